sr_bank_sequencer: RTL and testbench
====================================

# sr_bank_sequencer

Arbitrating controller for a bank of clocked SR flip-flops. Up to NREQ requesters post set/clear commands against individual bank bits. The block grants one command at a time in round-robin order, drives a single-bit S or R pulse into the bank, reads back Q, and acknowledges the requester. It guarantees that S and R are never high together on any bit, so the bank's forbidden S=R=1 input can never occur.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of SR flip-flops in the bank (1..32)
- IDX_W, $clog2(NBITS) (minimum 1), bit-index width
- PULSE, 1, cycles S or R is held high per command (1..4)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester command request
- req_op  in  NREQ  per-requester operation: 1 = set, 0 = clear
- req_idx  in  NREQ*IDX_W  per-requester target bit; requester i uses slice [i*IDX_W +: IDX_W]
- ack  out  NREQ  one-cycle completion pulse, one-hot
- s_out  out  NBITS  set lines to the bank, registered
- r_out  out  NBITS  reset lines to the bank, registered
- q_in  in  NBITS  bank Q outputs, read back
- busy  out  1  high in every non-IDLE state
- err  out  1  sticky error flag; cleared only by reset
- err_idx  out  IDX_W  index of the first failing command

## Operation
- Reset (reset low, asynchronous) sets the following; any in-flight command is abandoned with no ack:
  - state = IDLE, rr pointer = 0
  - s_out = 0, r_out = 0, ack = 0, busy = 0, err = 0, err_idx = 0
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - If any req bit is high, the arbiter grants the first requester at or after the pointer, searching upward with wrap from NREQ-1 to 0.
  - The FSM latches grant, op and idx, then moves to DRIVE.
  - If no req is high, the FSM stays in IDLE.
  - req is sampled only in IDLE.
- DRIVE:
  - For PULSE cycles, s_out = one-hot(idx) if op = 1, else r_out = one-hot(idx). The other vector is 0.
  - A down-counter of width 2 bits tracks the pulse. When the counter expires, the FSM moves to CHECK.
- CHECK:
  - s_out = r_out = 0.
  - ack[grant] = 1.
  - If q_in[idx] != op and err = 0, err is set to 1 and err_idx = idx.
  - The pointer becomes (grant + 1) mod NREQ.
  - The FSM returns to IDLE.
- Out-of-range idx (idx >= NBITS):
  - DRIVE is skipped and nothing is driven.
  - The FSM goes IDLE -> CHECK, acks, and sets err if err is clear.
- Requester rules:
  - req, req_op and req_idx must be held stable from assertion until ack.
  - req must be low in the cycle after ack; a requester still high in that cycle is treated as a new request.
- Invariant: (s_out & r_out) == 0 and popcount(s_out | r_out) <= 1 in every cycle.

## Timing
- Grant at IDLE edge k:
  - s_out/r_out high during cycles k+1 .. k+PULSE
  - CHECK (ack high) in cycle k+PULSE+1
  - IDLE in cycle k+PULSE+2
- Throughput: one command per PULSE+2 cycles. An out-of-range command takes 2 cycles.
- q_in is sampled in CHECK. The bank captures the pulse on the edge that ends the last DRIVE cycle, so no extra wait is needed.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait with req held.
- Fairness: with all NREQ requesting continuously, each requester is served once per NREQ grants.
- A request that arrives during DRIVE or CHECK is not lost; it is seen at the next IDLE.

## Structure
- Package sr_ctrl_pkg holds:
  - state enum (IDLE, DRIVE, CHECK)
  - OP_SET = 1'b1, OP_CLR = 1'b0
- Sub-module rr_arbiter (params NREQ): inputs req and pointer; outputs grant_idx and any_req. It is purely combinational.
- Pointer update and FSM stay in sr_bank_sequencer.
- The bank itself is external. The bench instantiates NBITS clocked SR flip-flops, with their reset driven by ~reset.

## Test plan
- Single set, then clear:
  - req0 set idx 3 -> s_out = 8'h08 for one cycle, ack[0] next cycle, q_in[3] = 1
  - req0 clear idx 3 -> r_out = 8'h08, q[3] = 0, err = 0
- Contention, all four requesters asserted at once, pointer 0:
  - grants go 0, 1, 2, 3
  - acks spaced 3 cycles apart with PULSE = 1
  - idx 0..3 set
- Back-to-back fairness: req1 and req2 held continuously -> grants alternate 1, 2, 1, 2 and neither is starved.
- Error detection:
  - bench forces q_in[5] low while idx 5 is being set -> err = 1, err_idx = 5
  - a later failure on idx 6 leaves err_idx = 5
- Out-of-range: NBITS = 6, idx 7 -> s_out and r_out stay 0, ack after 2 cycles, err = 1.
- Reset mid-operation:
  - reset low during DRIVE with PULSE = 3 -> s_out = 0 immediately, no ack, busy = 0, pointer = 0
  - after release, the same req is re-granted cleanly
  - S&R exclusivity is asserted throughout

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR bank sequencer.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after the
// pointer, wrapping from NREQ-1 back to 0.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] pointer,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_req
);

    logic w_found;

    always_comb begin : p_search
        int j;
        j         = 0;
        w_found   = 1'b0;
        grant_idx = '0;
        any_req   = |req;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(pointer) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_found && req[j]) begin
                w_found   = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/sr_bank_sequencer.sv
// Round-robin sequencer that pulses one S or R line of an external SR bank per
// command, reads Q back, acks the requester and latches the first failure.
module sr_bank_sequencer
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1,
    parameter int PULSE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_op,
    input  logic [NREQ*IDX_W-1:0]  req_idx,
    output logic [NREQ-1:0]        ack,
    output logic [NBITS-1:0]       s_out,
    output logic [NBITS-1:0]       r_out,
    input  logic [NBITS-1:0]       q_in,
    output logic                   busy,
    output logic                   err,
    output logic [IDX_W-1:0]       err_idx
);

    localparam int         PTR_W    = $clog2(NREQ);
    localparam logic [1:0] CNT_INIT = 2'(PULSE - 1);

    state_e             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_grant;
    logic               r_op;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_cnt;
    logic [NBITS-1:0]   r_s;
    logic [NBITS-1:0]   r_r;
    logic [NREQ-1:0]    r_ack;
    logic               r_busy;
    logic               r_err;
    logic [IDX_W-1:0]   r_err_idx;

    logic               w_any;
    logic [PTR_W-1:0]   w_gnt;
    logic               w_gnt_op;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_ok;
    logic [NBITS-1:0]   w_gnt_vec;
    logic [NBITS-1:0]   w_cur_vec;
    logic               w_cur_ok;
    logic               w_q_bit;
    logic [PTR_W-1:0]   w_next_ptr;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (req),
        .pointer   (r_ptr),
        .grant_idx (w_gnt),
        .any_req   (w_any)
    );

    assign w_gnt_op   = req_op[w_gnt];
    assign w_gnt_idx  = req_idx[int'(w_gnt)*IDX_W +: IDX_W];
    assign w_gnt_ok   = int'(w_gnt_idx) < NBITS;
    assign w_gnt_vec  = NBITS'(1) << w_gnt_idx;
    assign w_cur_vec  = NBITS'(1) << r_idx;
    assign w_cur_ok   = int'(r_idx) < NBITS;
    assign w_q_bit    = |(q_in & w_cur_vec);
    assign w_next_ptr = (r_grant == PTR_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_op      <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_s       <= '0;
            r_r       <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_gnt;
                        r_op    <= w_gnt_op;
                        r_idx   <= w_gnt_idx;
                        r_busy  <= 1'b1;
                        if (w_gnt_ok) begin
                            r_state <= DRIVE;
                            r_cnt   <= CNT_INIT;
                            r_s     <= (w_gnt_op == OP_SET) ? w_gnt_vec : '0;
                            r_r     <= (w_gnt_op == OP_CLR) ? w_gnt_vec : '0;
                        end else begin
                            // Bit does not exist: skip the pulse, report via CHECK.
                            r_state <= CHECK;
                            r_ack   <= NREQ'(1) << w_gnt;
                        end
                    end
                end
                DRIVE: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= CHECK;
                        r_s     <= '0;
                        r_r     <= '0;
                        r_ack   <= NREQ'(1) << r_grant;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_next_ptr;
                    if (!r_err && (!w_cur_ok || (w_q_bit != r_op))) begin
                        r_err     <= 1'b1;
                        r_err_idx <= r_idx;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_s     <= '0;
                    r_r     <= '0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign s_out   = r_s;
    assign r_out   = r_r;
    assign busy    = r_busy;
    assign err     = r_err;
    assign err_idx = r_err_idx;

endmodule

// File: tb/tb_sr_bank_sequencer.sv
// Scoreboard bench: a round-robin reference model predicts every ack, pulse and
// error state; a monitor compares them as the DUT acks, against a modelled SR bank.
module tb_sr_bank_sequencer;

    localparam int NREQ  = 4;
    localparam int NBITS = 6;
    localparam int IDX_W = 3;
    localparam int PULSE = 3;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*IDX_W-1:0] req_idx;
    logic [NREQ-1:0]       ack;
    logic [NBITS-1:0]      s_out;
    logic [NBITS-1:0]      r_out;
    logic [NBITS-1:0]      q_in;
    logic                  busy;
    logic                  err;
    logic [IDX_W-1:0]      err_idx;

    logic [NBITS-1:0]      bank_q;
    logic [NBITS-1:0]      fault;
    logic                  bank_rst;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        int               gnt;
        logic [NBITS-1:0] s;
        logic [NBITS-1:0] r;
        int               pulses;
        int               busy_cyc;
        logic             err;
        logic [IDX_W-1:0] err_idx;
    } exp_t;

    exp_t             sb[$];
    int               m_ptr;
    logic             m_err;
    logic [IDX_W-1:0] m_err_idx;
    logic [NBITS-1:0] m_bank;
    int               left[NREQ];
    logic             cmd_op[NREQ];
    int               cmd_idx[NREQ];

    sr_bank_sequencer #(
        .NREQ  (NREQ),
        .NBITS (NBITS),
        .IDX_W (IDX_W),
        .PULSE (PULSE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_op  (req_op),
        .req_idx (req_idx),
        .ack     (ack),
        .s_out   (s_out),
        .r_out   (r_out),
        .q_in    (q_in),
        .busy    (busy),
        .err     (err),
        .err_idx (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External bank of clocked SR flip-flops; a fault mask pulls Q low on read-back.
    assign bank_rst = ~reset;
    always @(posedge clk or posedge bank_rst) begin
        if (bank_rst) begin
            bank_q <= '0;
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if (s_out[i]) bank_q[i] <= 1'b1;
                else if (r_out[i]) bank_q[i] <= 1'b0;
            end
        end
    end
    assign q_in = bank_q & ~fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pending_left();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += left[i];
        return n;
    endfunction

    task automatic post(input int i, input logic op, input int idx, input int cnt);
        cmd_op[i]  = op;
        cmd_idx[i] = idx;
        left[i]    = cnt;
        req_op[i]  = op;
        req_idx[i*IDX_W +: IDX_W] = IDX_W'(idx);
        req[i]     = 1'b1;
    endtask

    // Serve outstanding commands round-robin from the model pointer.
    task automatic plan();
        int   l[NREQ];
        int   g;
        bit   bad;
        exp_t e;
        for (int i = 0; i < NREQ; i++) l[i] = left[i];
        forever begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && l[(m_ptr + k) % NREQ] > 0) g = (m_ptr + k) % NREQ;
            end
            if (g < 0) break;
            e.gnt = g;
            e.s   = '0;
            e.r   = '0;
            if (cmd_idx[g] < NBITS) begin
                if (cmd_op[g]) e.s[cmd_idx[g]] = 1'b1;
                else           e.r[cmd_idx[g]] = 1'b1;
                e.pulses   = PULSE;
                e.busy_cyc = PULSE + 1;
                m_bank[cmd_idx[g]] = cmd_op[g];
                bad = cmd_op[g] && fault[cmd_idx[g]];
            end else begin
                e.pulses   = 0;
                e.busy_cyc = 1;
                bad = 1'b1;
            end
            if (bad && !m_err) begin
                m_err     = 1'b1;
                m_err_idx = IDX_W'(cmd_idx[g]);
            end
            e.err     = m_err;
            e.err_idx = m_err_idx;
            sb.push_back(e);
            l[g]--;
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr     = 0;
        m_err     = 1'b0;
        m_err_idx = '0;
        m_bank    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk);
            if (sb.size() == 0 && pending_left() == 0) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            fails++;
            $display("FAIL timeout: %0d acks still outstanding, required 0", sb.size());
            sb.delete();
            req = '0;
            for (int i = 0; i < NREQ; i++) left[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("bank_q", 32'(bank_q), 32'(m_bank));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic rand_batch(input int max_idx, input bit faults);
        int mask;
        fault = faults ? NBITS'($urandom & $urandom & $urandom) : '0;
        mask  = $urandom_range(1, (1 << NREQ) - 1);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) post(i, 1'($urandom_range(0, 1)), $urandom_range(0, max_idx),
                              $urandom_range(1, 3));
        end
        plan();
        wait_idle(300);
        fault = '0;
    endtask

    // Requesters drop req during the ack cycle once their command count is used up.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (ack[i] && left[i] > 0) begin
                        left[i]--;
                        if (left[i] == 0) req[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        int               busy_cnt;
        int               drv_cnt;
        logic [NBITS-1:0] drv_s;
        logic [NBITS-1:0] drv_r;
        bit               pend;
        exp_t             e;
        exp_t             pe;
        busy_cnt = 0;
        drv_cnt  = 0;
        drv_s    = '0;
        drv_r    = '0;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt = 0;
                drv_cnt  = 0;
                drv_s    = '0;
                drv_r    = '0;
                pend     = 1'b0;
            end else begin
                check("s_and_r", 32'(s_out & r_out), 32'd0);
                check("single_line", 32'($countones(s_out | r_out) <= 1), 32'd1);
                if (pend) begin
                    check("err", 32'(err), 32'(pe.err));
                    check("err_idx", 32'(err_idx), 32'(pe.err_idx));
                    pend = 1'b0;
                end
                if (busy) busy_cnt++;
                else      busy_cnt = 0;
                if ((s_out | r_out) != '0) begin
                    drv_s |= s_out;
                    drv_r |= r_out;
                    drv_cnt++;
                end
                if (ack != '0) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL unexpected_ack: got %0h, required none", ack);
                    end else begin
                        e = sb.pop_front();
                        check("ack", 32'(ack), 32'(1) << e.gnt);
                        check("s_pulse", 32'(drv_s), 32'(e.s));
                        check("r_pulse", 32'(drv_r), 32'(e.r));
                        check("pulse_len", 32'(drv_cnt), 32'(e.pulses));
                        check("ack_latency", 32'(busy_cnt), 32'(e.busy_cyc));
                        pe   = e;
                        pend = 1'b1;
                    end
                    drv_cnt = 0;
                    drv_s   = '0;
                    drv_r   = '0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit seen;
        reset   = 1'b0;
        req     = '0;
        req_op  = '0;
        req_idx = '0;
        fault   = '0;
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        model_reset();
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_s", 32'(s_out), 32'd0);
        check("rst_r", 32'(r_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_idx", 32'(err_idx), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        // Single set then clear of bit 3.
        post(0, 1'b1, 3, 1); plan(); wait_idle(50);
        post(0, 1'b0, 3, 1); plan(); wait_idle(50);

        // All four contend at once.
        for (int i = 0; i < NREQ; i++) post(i, 1'b1, i, 1);
        plan(); wait_idle(100);

        // Two requesters held for several commands each must alternate.
        post(1, 1'b1, 4, 4); post(2, 1'b0, 5, 4); plan(); wait_idle(100);

        for (int n = 0; n < 25; n++) rand_batch(NBITS - 1, 1'b0);

        // Reset in the middle of a pulse; pointer lands on 2 beforehand.
        post(1, 1'b0, 0, 1); plan(); wait_idle(50);
        post(2, 1'b1, 4, 1); plan();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (s_out != '0) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_s", 32'(s_out), 32'd0);
        check("mid_rst_r", 32'(r_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        post(1, 1'b1, 1, 1);
        plan();
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_idle(100);

        // Read-back failures: first one is latched, later one ignored.
        fault = 6'b100000; post(0, 1'b1, 5, 1); plan(); wait_idle(50);
        fault = 6'b010000; post(1, 1'b1, 4, 1); plan(); wait_idle(50);
        fault = '0;

        // Out-of-range bit indices.
        @(posedge clk);
        #1;
        do_reset();
        #1;
        check("err_cleared", 32'(err), 32'd0);
        post(2, 1'b1, 7, 1); plan(); wait_idle(50);
        post(3, 1'b0, 6, 1); plan(); wait_idle(50);

        @(posedge clk);
        #1;
        do_reset();
        for (int n = 0; n < 25; n++) rand_batch((1 << IDX_W) - 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
